// File: rtl/mem_bus_pkg.sv
// Shared definitions for the address-change memory handshake: bus width
// defaults and the initiator state encoding.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-phase cycle counter; flags expiry once TIMEOUT cycles have elapsed
// since the last clear, then holds.
module mem_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_master.sv
// Core-side initiator: issues one read/write on the memory bus, follows the
// ready fall/rise handshake and returns data plus a done pulse or timeout.
module mem_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] memory_addr,
  output logic              memory_w,
  output logic [DATA_W-1:0] memory_wdata,
  input  logic [DATA_W-1:0] memory_rdata,
  input  logic              memory_ready
);

  state_t r_state, w_next;

  logic              r_same;
  logic              r_err;
  logic              r_w;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic w_accept, w_capture, w_timeout, w_cnt_clr, w_cnt_en, w_expired;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_cnt_clr),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          w_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_clr = 1'b1;
        // Responder only handshakes on an address change; reuse current data.
        if (r_same) begin
          w_capture = !r_w;
          w_next    = ST_DONE;
        end else begin
          w_next = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!memory_ready) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_WAIT_HIGH;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (memory_ready) begin
          w_capture = !r_w;
          w_next    = ST_DONE;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_same  <= 1'b0;
      r_err   <= 1'b0;
      r_w     <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr_in;
        r_w     <= we;
        r_wdata <= wdata_in;
        r_err   <= 1'b0;
        r_same  <= (addr_in == r_addr);
      end
      if (w_capture) begin
        r_rdata <= memory_rdata;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_w <= 1'b0;
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign err          = r_err;
  assign rdata_out    = r_rdata;
  assign memory_addr  = r_addr;
  assign memory_w     = r_w;
  assign memory_wdata = r_wdata;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: behavioural responder with read latency 1 / write
// latency 2, a request table with a scoreboard queue, and corner sequences.
module tb_mem_master;
  import mem_bus_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] wdata_in = '0;
  logic          busy, done, err;
  logic [DW-1:0] rdata_out;
  logic [AW-1:0] memory_addr;
  logic          memory_w;
  logic [DW-1:0] memory_wdata;
  logic [DW-1:0] memory_rdata;
  logic          memory_ready;

  mem_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .we           (we),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata_out    (rdata_out),
    .memory_addr  (memory_addr),
    .memory_w     (memory_w),
    .memory_wdata (memory_wdata),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready)
  );

  always #5 clk = ~clk;

  // Responder: drops ready one registered cycle after an address change,
  // raises it after the access latency. mute = never drop, stuck = never rise.
  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] r_last;
  logic [1:0]    r_lat;
  logic          mute = 1'b0;
  logic          stuck = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10]   <= 16'hBEEF;
      mem[8'h30]   <= 16'h5A5A;
      memory_ready <= 1'b1;
      r_last       <= '0;
      r_lat        <= '0;
    end else if (memory_addr != r_last) begin
      r_last <= memory_addr;
      if (!mute) begin
        memory_ready <= 1'b0;
        r_lat        <= memory_w ? 2'd1 : 2'd0;
      end
    end else if (!memory_ready && !stuck) begin
      if (r_lat == 2'd0) begin
        memory_ready <= 1'b1;
        if (memory_w) mem[memory_addr[7:0]] <= memory_wdata;
      end else begin
        r_lat <= r_lat - 2'd1;
      end
    end
  end

  assign memory_rdata = mem[memory_addr[7:0]];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } vec_t;

  vec_t tbl [6];
  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and compare against the scoreboard when done appears.
  task automatic do_req(input vec_t v);
    vec_t e;
    int   n;
    logic w_bad;
    logic got;
    @(negedge clk);
    req = 1'b1; we = v.we; addr_in = v.addr; wdata_in = v.wdata;
    exp_q.push_back(v);
    @(negedge clk);
    req = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0; w_bad = 1'b0; got = 1'b0;
    while (n < 40 && !got) begin
      if (memory_w !== v.we) w_bad = 1'b1;
      if (done === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    e = exp_q.pop_front();
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", n, e.lat);
    check("rdata_out", {16'd0, rdata_out}, {16'd0, e.rdata});
    check("err", {31'd0, err}, {31'd0, e.err});
    check("memory_w_held", {31'd0, w_bad}, 32'd0);
    check("memory_addr", {16'd0, memory_addr}, {16'd0, e.addr});
    if (e.we) check("memory_wdata", {16'd0, memory_wdata}, {16'd0, e.wdata});
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("memory_w_cleared", {31'd0, memory_w}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic a_bad;
    vec_t v;

    tbl[0] = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'hBEEF, err: 1'b0, lat: 3};
    tbl[1] = '{we: 1'b1, addr: 16'h0020, wdata: 16'h1234, rdata: 16'hBEEF, err: 1'b0, lat: 4};
    tbl[2] = '{we: 1'b0, addr: 16'h0020, wdata: 16'h0000, rdata: 16'h1234, err: 1'b0, lat: 1};
    tbl[3] = '{we: 1'b0, addr: 16'h0030, wdata: 16'h0000, rdata: 16'h5A5A, err: 1'b0, lat: 3};
    tbl[4] = '{we: 1'b1, addr: 16'h0040, wdata: 16'h0F0F, rdata: 16'h5A5A, err: 1'b0, lat: 4};
    tbl[5] = '{we: 1'b0, addr: 16'h0040, wdata: 16'h0000, rdata: 16'h0F0F, err: 1'b0, lat: 1};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", {16'd0, rdata_out}, 32'd0);
    check("rst_addr", {16'd0, memory_addr}, 32'd0);
    check("rst_w", {31'd0, memory_w}, 32'd0);
    check("rst_wdata", {16'd0, memory_wdata}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) do_req(tbl[i]);

    // Silent responder: ready never drops.
    mute = 1'b1;
    do_req('{we: 1'b0, addr: 16'h0050, wdata: 16'h0, rdata: 16'h0F0F, err: 1'b1, lat: 17});
    mute = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    do_req('{we: 1'b0, addr: 16'h0010, wdata: 16'h0, rdata: 16'hBEEF, err: 1'b0, lat: 3});

    // Ready stuck low: timeout counted from entry to WAIT_HIGH.
    stuck = 1'b1;
    do_req('{we: 1'b0, addr: 16'h0060, wdata: 16'h0, rdata: 16'hBEEF, err: 1'b1, lat: 18});
    stuck = 1'b0;
    repeat (3) @(negedge clk);

    // req held high with a changing address: no re-acceptance while busy.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr_in = 16'h0010;
    @(negedge clk);
    addr_in = 16'h0070;
    n = 0; a_bad = 1'b0;
    while (n < 40 && done !== 1'b1) begin
      if (memory_addr !== 16'h0010) a_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    check("held_latency", n, 32'd3);
    check("held_addr_stable", {31'd0, a_bad}, 32'd0);
    check("held_rdata", {16'd0, rdata_out}, 32'h0000BEEF);
    @(negedge clk);
    check("held_no_reaccept", {16'd0, memory_addr}, 32'h00000010);
    check("held_idle", {31'd0, busy}, 32'd0);

    // Reset pulse during WAIT_HIGH with req held.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr_in = 16'h0020;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_rdata", {16'd0, rdata_out}, 32'd0);
    check("mid_rst_addr", {16'd0, memory_addr}, 32'd0);
    check("mid_rst_w", {31'd0, memory_w}, 32'd0);
    check("mid_rst_wdata", {16'd0, memory_wdata}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    v = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0, rdata: 16'hBEEF, err: 1'b0, lat: 3};
    do_req(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
